// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-read-port register file with byte-enabled write, write-to-read bypass
// and an integrated busy scoreboard that the issue stage sets and writeback clears.
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       wa,
    input  logic [DATA_W-1:0]       wd,
    input  logic [DATA_W/8-1:0]     wbe,
    input  logic [NREAD*ADDR_W-1:0] ra,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic [NREAD-1:0]        rready,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_rd,
    output logic [ADDR_W:0]         busy_cnt
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [DATA_W-1:0] wmerge;
    logic              wr_ok, iss_ok, inc, dec;

    // Strobes gate every use of wa/iss_rd so undriven addresses cannot leak X.
    always_comb begin
        wr_ok    = we && !(ZERO_REG != 0 && wa == '0);
        iss_ok   = iss_valid && !(ZERO_REG != 0 && iss_rd == '0);
        wmerge   = mem[wa];
        for (int i = 0; i < NB; i++)
            wmerge[8*i +: 8] = wbe[i] ? wd[8*i +: 8] : mem[wa][8*i +: 8];
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wa] = 1'b0;
        if (iss_ok)
            busy_nxt[iss_rd] = 1'b1;
        inc      = iss_ok && !busy[iss_rd];
        dec      = wr_ok && busy[wa] && !(iss_ok && iss_rd == wa);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < DEPTH; r++)
                mem[r] <= '0;
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok)
                mem[wa] <= wmerge;
            busy     <= busy_nxt;
            busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              hit;
        assign a   = ra[p*ADDR_W +: ADDR_W];
        assign hit = BYPASS != 0 && wr_ok && wa == a;
        assign rdata[p*DATA_W +: DATA_W] = (ZERO_REG != 0 && a == '0) ? '0 : hit ? wmerge : mem[a];
        assign rready[p] = !busy[a] || hit;
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: vector table plus model-driven sequences; a bypassing and a non-bypassing
// instance share stimulus, expectations are queued at drive time and checked on the falling edge.
module tb_regfile_mp_sb;
    logic        Clk = 0, Reset, we, iss_valid;
    logic [4:0]  wa, iss_rd;
    logic [31:0] wd;
    logic [3:0]  wbe;
    logic [9:0]  ra;
    logic [63:0] rdata, nb_rdata;
    logic [1:0]  rready, nb_rready;
    logic [5:0]  busy_cnt, nb_busy_cnt;

    always #5 Clk = ~Clk;

    regfile_mp_sb u_dut (
        .Clk(Clk), .Reset(Reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe), .ra(ra),
        .rdata(rdata), .rready(rready), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_cnt(busy_cnt)
    );

    regfile_mp_sb #(.BYPASS(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe), .ra(ra),
        .rdata(nb_rdata), .rready(nb_rready), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy_cnt(nb_busy_cnt)
    );

    typedef struct {
        string            nm;
        logic [1:0][31:0] r, n;
        logic [1:0]       rr, nrr;
        logic [5:0]       cnt;
    } exp_t;

    typedef struct {
        bit          rst, w;
        logic [4:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          v;
        logic [4:0]  ir, ra0, ra1;
        exp_t        e;
    } vec_t;

    vec_t        tv[$];
    exp_t        q[$];
    exp_t        ce;
    int          ntests = 0, nfail = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (q.size() != 0) begin
            ce = q.pop_front();
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("%s rdata%0d", ce.nm, p), rdata[p*32 +: 32], ce.r[p]);
                chk($sformatf("%s nb_rdata%0d", ce.nm, p), nb_rdata[p*32 +: 32], ce.n[p]);
            end
            chk({ce.nm, " rready"}, 32'(rready), 32'(ce.rr));
            chk({ce.nm, " nb_rready"}, 32'(nb_rready), 32'(ce.nrr));
            chk({ce.nm, " busy_cnt"}, 32'(busy_cnt), 32'(ce.cnt));
            chk({ce.nm, " nb_busy_cnt"}, 32'(nb_busy_cnt), 32'(ce.cnt));
        end
    end

    function automatic void row(input string nm, input bit rst, w, input logic [4:0] a,
                                input logic [31:0] d, input logic [3:0] be, input bit v,
                                input logic [4:0] ir, ra0, ra1, input logic [31:0] r0, r1,
                                input logic [1:0] rr, input logic [5:0] cnt,
                                input logic [31:0] n0, n1, input logic [1:0] nrr);
        vec_t t;
        t.rst = rst; t.w = w; t.a = a; t.d = d; t.be = be; t.v = v;
        t.ir = ir; t.ra0 = ra0; t.ra1 = ra1;
        t.e.nm = nm; t.e.r = {r1, r0}; t.e.n = {n1, n0};
        t.e.rr = rr; t.e.nrr = nrr; t.e.cnt = cnt;
        tv.push_back(t);
    endfunction

    task automatic drive(input bit r, w, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit v, input logic [4:0] ir, ra0, ra1);
        Reset = r; we = w; wa = a; wd = d; wbe = be;
        iss_valid = v; iss_rd = ir; ra = {ra1, ra0};
    endtask

    // Reference: predicts this cycle's outputs from model state, then advances the model.
    task automatic mstep(input string nm, input bit r, w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] be, input bit v,
                         input logic [4:0] ir, ra0, ra1);
        exp_t        e;
        logic [31:0] mg, base;
        logic [4:0]  rp [2];
        bit          hit;
        rp[0] = ra0; rp[1] = ra1;
        mg = m_reg[a];
        for (int b = 0; b < 4; b++)
            if (be[b]) mg[8*b +: 8] = d[8*b +: 8];
        e.nm = nm;
        e.cnt = 6'($countones(m_busy));
        for (int p = 0; p < 2; p++) begin
            hit = w && a == rp[p] && a != 0;
            base = (rp[p] == 0) ? 32'h0 : m_reg[rp[p]];
            e.r[p] = (rp[p] != 0 && hit) ? mg : base;
            e.n[p] = base;
            e.rr[p] = !m_busy[rp[p]] || hit;
            e.nrr[p] = !m_busy[rp[p]];
        end
        drive(r, w, a, d, be, v, ir, ra0, ra1);
        q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 0;
            m_busy = 0;
        end else begin
            if (w && a != 0) begin
                m_reg[a] = mg;
                m_busy[a] = 0;
            end
            if (v && ir != 0) m_busy[ir] = 1;
        end
        @(posedge Clk); #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge Clk);
        #1;
        row("t1_rst_state", 0, 0, 0, 0, 0, 0, 0, 5, 31, 0, 0, 3, 0, 0, 0, 3);
        row("t1_wr5", 0, 1, 5, 32'hDEADBEEF, 4'hF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 3, 0, 0, 0, 3);
        row("t1_rst_cyc", 1, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 32'hDEADBEEF, 3);
        row("t1_after", 0, 0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 3, 0, 0, 0, 3);
        row("t2_init", 0, 1, 3, 32'h11223344, 4'hF, 0, 0, 3, 3, 32'h11223344, 32'h11223344, 3, 0, 0, 0, 3);
        row("t2_bytes", 0, 1, 3, 32'hAABBCCDD, 4'b0101, 0, 0, 3, 3, 32'h11BB33DD, 32'h11BB33DD, 3, 0, 32'h11223344, 32'h11223344, 3);
        row("t2_read", 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'h11BB33DD, 32'h11BB33DD, 3, 0, 32'h11BB33DD, 32'h11BB33DD, 3);
        row("t3_old", 0, 1, 7, 32'hCAFEF00D, 4'hF, 0, 0, 7, 7, 32'hCAFEF00D, 32'hCAFEF00D, 3, 0, 0, 0, 3);
        row("t3_bypass", 0, 1, 7, 32'h12345678, 4'hF, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 3, 0, 32'hCAFEF00D, 32'hCAFEF00D, 3);
        row("t3_next", 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 3, 0, 32'h12345678, 32'h12345678, 3);
        row("t4_zero", 0, 1, 0, 32'hFFFFFFFF, 4'hF, 1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 3);
        row("t4_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 3);
        row("t5_iss4", 0, 0, 0, 0, 0, 1, 4, 4, 9, 0, 0, 3, 0, 0, 0, 3);
        row("t5_iss9", 0, 0, 0, 0, 0, 1, 9, 4, 9, 0, 0, 2, 1, 0, 0, 2);
        row("t5_wb_iss4", 0, 1, 4, 32'h44, 4'hF, 1, 4, 4, 9, 32'h44, 0, 1, 2, 0, 0, 0);
        row("t5_still4", 0, 0, 0, 0, 0, 0, 0, 4, 9, 32'h44, 0, 0, 2, 32'h44, 0, 0);
        row("t5_wb9", 0, 1, 9, 32'h99, 4'hF, 0, 0, 4, 9, 32'h44, 32'h99, 2, 2, 32'h44, 0, 0);
        row("t5_after9", 0, 0, 0, 0, 0, 0, 0, 4, 9, 32'h44, 32'h99, 2, 1, 32'h44, 32'h99, 2);
        row("t5_wb4_nobe", 0, 1, 4, 32'hFFFFFFFF, 4'h0, 0, 0, 4, 4, 32'h44, 32'h44, 3, 1, 32'h44, 32'h44, 0);
        row("t5_clear4", 0, 0, 0, 0, 0, 0, 0, 4, 4, 32'h44, 32'h44, 3, 0, 32'h44, 32'h44, 3);
        row("t5_wb_idle", 0, 1, 9, 0, 4'hF, 0, 0, 9, 9, 0, 0, 3, 0, 32'h99, 32'h99, 3);
        row("t5_idle_chk", 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 0, 3, 0, 0, 0, 3);
        foreach (tv[i]) begin
            drive(tv[i].rst, tv[i].w, tv[i].a, tv[i].d, tv[i].be, tv[i].v, tv[i].ir, tv[i].ra0, tv[i].ra1);
            q.push_back(tv[i].e);
            @(posedge Clk); #1;
        end

        // Resync the model with a known-zero state before the model-driven sequences.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        m_busy = 0;
        @(posedge Clk); #1;

        mstep("t6_wr2", 0, 1, 2, 32'h22222222, 4'hF, 0, 0, 2, 2);
        for (int i = 1; i <= 8; i++)
            mstep($sformatf("t6_iss%0d", i), 0, 0, 0, 0, 0, 1, 5'(i), 5'(i), 2);
        mstep("t6_rst_mid", 1, 1, 2, 32'h5A5A5A5A, 4'hF, 1, 9, 2, 1);
        mstep("t6_after", 0, 0, 0, 0, 0, 0, 0, 2, 1);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] a;
            a = 5'($urandom);
            mstep("soak", $urandom_range(0, 63) == 0, 1'($urandom), a, $urandom, 4'($urandom),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0) ? a : 5'($urandom));
        end

        if (q.size() != 0) begin
            nfail++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
